// File: rtl/fifo_ms_place_pkg.sv
// fifo_ms_place_pkg: width helpers shared by the multi-stream place FIFO
package fifo_ms_place_pkg;
  function automatic int clog2(input int n);
    int r = 0;
    for (int i = 0; (1 << i) < n; i++) r = i + 1;
    return r;
  endfunction
  function automatic int ptr_w(input int depth);
    return clog2(depth);
  endfunction
  function automatic int cnt_w(input int depth);
    return clog2(depth) + 1;
  endfunction
  function automatic int phase_w(input int flux);
    return clog2(flux) < 1 ? 1 : clog2(flux);
  endfunction
endpackage

// File: rtl/fifo_ms_place_lane.sv
// fifo_ms_place_lane: single-flux first-word-fall-through FIFO lane
module fifo_ms_place_lane
  import fifo_ms_place_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = ptr_w(DEPTH),
  localparam int CW = cnt_w(DEPTH)
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             wr,
  input  logic [WIDTH-1:0] datain,
  input  logic             rd,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dataout,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic we, re;
  // Flags and head token come straight from pre-edge state; no write-to-read bypass
  always_comb begin
    full = count == CW'(DEPTH);
    empty = count == '0;
    we = wr && !full;
    re = rd && !empty;
    dataout = mem[rptr];
  end
  // Storage, pointers and occupancy; pointers wrap naturally at AW bits
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      mem <= '{default: '0};
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      if (we) mem[wptr] <= datain;
      if (we) wptr <= wptr + 1'b1;
      if (re) rptr <= rptr + 1'b1;
      count <= count + CW'(we) - CW'(re);
    end
  end
endmodule

// File: rtl/fifo_ms_place.sv
// fifo_ms_place: merges FLUX writer lanes into one reader in fixed round-robin order
module fifo_ms_place
  import fifo_ms_place_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int FLUX = 2,
  localparam int PW = phase_w(FLUX),
  localparam int CW = cnt_w(DEPTH)
) (
  input  logic                  ck,
  input  logic                  rst,
  input  logic [FLUX-1:0]       wr,
  input  logic [WIDTH*FLUX-1:0] datain,
  output logic [FLUX-1:0]       full,
  input  logic                  rd,
  output logic                  empty,
  output logic [WIDTH-1:0]      dataout,
  output logic [PW-1:0]         phase
);
  logic [FLUX-1:0] lane_empty;
  logic [WIDTH-1:0] lane_data [FLUX];
  logic [CW-1:0] lane_count [FLUX];
  for (genvar f = 0; f < FLUX; f++) begin : g_lane
    fifo_ms_place_lane #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_lane (
      .ck(ck),
      .rst(rst),
      .wr(wr[f]),
      .datain(datain[f*WIDTH +: WIDTH]),
      .rd(rd && phase == PW'(f)),
      .full(full[f]),
      .empty(lane_empty[f]),
      .dataout(lane_data[f]),
      .count(lane_count[f])
    );
  end
  // Reader sees only the lane selected by the current phase
  always_comb begin
    empty = lane_empty[phase];
    dataout = lane_data[phase];
  end
  // Phase advances only when the current lane actually hands over a token
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) phase <= '0;
    else if (rd && lane_count[phase] != '0) phase <= phase == PW'(FLUX - 1) ? '0 : phase + 1'b1;
  end
endmodule
